// File: rtl/ram_dp_be.sv
// ram_dp_be: simple-dual-port RAM with per-byte write enables, clear-on-reset sequencer,
// write-first bypass and range errors. Define RAM_PARITY_EN for per-lane even parity.
module ram_dp_be #(
   parameter int WORD_WIDTH = 32,
   parameter int BYTE_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   output logic                             init_done_o,
   input  logic                             wr_i,
   input  logic [WORD_WIDTH/BYTE_WIDTH-1:0] wr_be_i,
   input  logic [ADDR_WIDTH-1:0]            wr_addr_i,
   input  logic [WORD_WIDTH-1:0]            wr_data_i,
   output logic                             ack_wr_o,
   output logic                             err_wr_o,
   input  logic                             rd_i,
   input  logic [ADDR_WIDTH-1:0]            rd_addr_i,
   output logic                             ack_rd_o,
   output logic [WORD_WIDTH-1:0]            rd_data_o,
`ifdef RAM_PARITY_EN
   output logic                             par_err_o,
   input  logic                             par_flip_i,
`endif
   output logic                             err_rd_o
);

   localparam int                    LANES   = WORD_WIDTH / BYTE_WIDTH;
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);

   generate
      if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
         $error("ram_dp_be: WORD_WIDTH must be a multiple of BYTE_WIDTH");
      end
      if (DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
         $error("ram_dp_be: DEPTH must be in 1..2**ADDR_WIDTH");
      end
      if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
         $error("ram_dp_be: RD_LATENCY must be 1 or 2");
      end
   endgenerate

   function automatic logic [WORD_WIDTH-1:0] f_merge(input logic [WORD_WIDTH-1:0] old_w,
                                                     input logic [WORD_WIDTH-1:0] new_w,
                                                     input logic [LANES-1:0]      be);
      logic [WORD_WIDTH-1:0] w;
      w = old_w;
      for (int k = 0; k < LANES; k++) begin
         if (be[k]) w[k*BYTE_WIDTH +: BYTE_WIDTH] = new_w[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
      return w;
   endfunction

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_clr_ptr;
   logic                    r_init_done;
   logic [WORD_WIDTH-1:0]   r_mem [DEPTH];
   logic                    r_ack_wr, r_err_wr;
   logic                    r_ack_rd, r_err_rd;
   logic [WORD_WIDTH-1:0]   r_rd_data;

   logic                    w_ready, w_wr_go, w_rd_go, w_wr_in, w_rd_in, w_byp;
   logic [WORD_WIDTH-1:0]   w_rd_word;

   // Requests only count once the clear sequence is over and reset is low.
   assign w_ready = (r_state == S_READY) && !rst_i;
   assign w_wr_go = w_ready && wr_i;
   assign w_rd_go = w_ready && rd_i;
   assign w_wr_in = {1'b0, wr_addr_i} < DEPTH_C;
   assign w_rd_in = {1'b0, rd_addr_i} < DEPTH_C;
   assign w_byp   = w_wr_go && w_wr_in && (wr_addr_i == rd_addr_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_INIT;
         r_clr_ptr   <= '0;
         r_init_done <= 1'b0;
      end else if (r_state == S_INIT) begin
         r_clr_ptr <= r_clr_ptr + 1'b1;
         if (r_clr_ptr == LAST_C) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && r_state == S_INIT) begin
         r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_go && w_wr_in) begin
         r_mem[wr_addr_i] <= f_merge(r_mem[wr_addr_i], wr_data_i, wr_be_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ack_wr <= 1'b0;
         r_err_wr <= 1'b0;
      end else begin
         r_ack_wr <= w_wr_go;
         r_err_wr <= w_wr_go && !w_wr_in;
      end
   end

   // Write-first: a same-address write in this cycle overlays the stored word.
   always_comb begin
      w_rd_word = '0;
      if (w_rd_in) begin
         if (w_byp) w_rd_word = f_merge(r_mem[rd_addr_i], wr_data_i, wr_be_i);
         else       w_rd_word = r_mem[rd_addr_i];
      end
   end

`ifdef RAM_PARITY_EN
   function automatic logic [LANES-1:0] f_lane_par(input logic [WORD_WIDTH-1:0] w);
      logic [LANES-1:0] p;
      for (int k = 0; k < LANES; k++) p[k] = ^w[k*BYTE_WIDTH +: BYTE_WIDTH];
      return p;
   endfunction

   logic [LANES-1:0] r_par [DEPTH];
   logic             r_par_err;
   logic             w_par_bad;
   logic [LANES-1:0] w_par_new;

   assign w_par_new = f_lane_par(wr_data_i) ^ {LANES{par_flip_i}};

   always_ff @(posedge clk_i) begin
      if (!rst_i && r_state == S_INIT) begin
         r_par[r_clr_ptr] <= '0;
      end else if (w_wr_go && w_wr_in) begin
         r_par[wr_addr_i] <= (r_par[wr_addr_i] & ~wr_be_i) | (w_par_new & wr_be_i);
      end
   end

   always_comb begin
      w_par_bad = 1'b0;
      if (w_rd_in && !w_byp) w_par_bad = |(f_lane_par(r_mem[rd_addr_i]) ^ r_par[rd_addr_i]);
   end

   assign par_err_o = r_par_err;
`endif

   generate
      if (RD_LATENCY == 1) begin : g_lat1
         // p0: single registered output stage
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_ack_rd  <= 1'b0;
               r_err_rd  <= 1'b0;
               r_rd_data <= '0;
`ifdef RAM_PARITY_EN
               r_par_err <= 1'b0;
`endif
            end else begin
               r_ack_rd <= w_rd_go;
               r_err_rd <= w_rd_go && !w_rd_in;
`ifdef RAM_PARITY_EN
               r_par_err <= w_rd_go && w_par_bad;
`endif
               if (w_rd_go) r_rd_data <= w_rd_word;
            end
         end
      end else begin : g_lat2
         logic                  r_vld_p0, r_err_p0;
         logic [WORD_WIDTH-1:0] r_data_p0;
`ifdef RAM_PARITY_EN
         logic                  r_par_p0;
`endif
         // p0: sample the array
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_vld_p0 <= 1'b0;
               r_err_p0 <= 1'b0;
`ifdef RAM_PARITY_EN
               r_par_p0 <= 1'b0;
`endif
            end else begin
               r_vld_p0 <= w_rd_go;
               r_err_p0 <= !w_rd_in;
`ifdef RAM_PARITY_EN
               r_par_p0 <= w_par_bad;
`endif
            end
         end

         always_ff @(posedge clk_i) begin
            if (w_rd_go) r_data_p0 <= w_rd_word;
         end

         // p1: output register
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               r_ack_rd  <= 1'b0;
               r_err_rd  <= 1'b0;
               r_rd_data <= '0;
`ifdef RAM_PARITY_EN
               r_par_err <= 1'b0;
`endif
            end else begin
               r_ack_rd <= r_vld_p0;
               r_err_rd <= r_vld_p0 && r_err_p0;
`ifdef RAM_PARITY_EN
               r_par_err <= r_vld_p0 && r_par_p0;
`endif
               if (r_vld_p0) r_rd_data <= r_data_p0;
            end
         end
      end
   endgenerate

   assign init_done_o = r_init_done;
   assign ack_wr_o    = r_ack_wr;
   assign err_wr_o    = r_err_wr;
   assign ack_rd_o    = r_ack_rd;
   assign err_rd_o    = r_err_rd;
   assign rd_data_o   = r_rd_data;

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances (DEPTH 16/latency 1 and DEPTH 12/latency 2) on shared stimulus,
// each compared every cycle against a word-array reference model.
module tb_ram_dp_be;

   logic        clk = 1'b0;
   logic        rst, wr, rd;
   logic [3:0]  be, wr_addr, rd_addr;
   logic [31:0] wr_data;

   logic        a_done, a_ackw, a_errw, a_ackr, a_errr;
   logic [31:0] a_data;
   logic        b_done, b_ackw, b_errw, b_ackr, b_errr;
   logic [31:0] b_data;

   always #5 clk = ~clk;

   ram_dp_be u_dut_a (
      .clk_i(clk), .rst_i(rst), .init_done_o(a_done),
      .wr_i(wr), .wr_be_i(be), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .ack_wr_o(a_ackw), .err_wr_o(a_errw),
      .rd_i(rd), .rd_addr_i(rd_addr), .ack_rd_o(a_ackr), .rd_data_o(a_data),
      .err_rd_o(a_errr)
   );

   ram_dp_be #(.DEPTH(12), .RD_LATENCY(2)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .init_done_o(b_done),
      .wr_i(wr), .wr_be_i(be), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .ack_wr_o(b_ackw), .err_wr_o(b_errw),
      .rd_i(rd), .rd_addr_i(rd_addr), .ack_rd_o(b_ackr), .rd_data_o(b_data),
      .err_rd_o(b_errr)
   );

   // reference model state, index 0 = instance a, 1 = instance b
   logic [31:0] mem [2][16];
   int          depth [2];
   int          lat [2];
   int          icnt [2];
   logic        pv [2];
   logic        pe [2];
   logic [31:0] pd [2];
   logic        e_done [2];
   logic        e_ackw [2];
   logic        e_errw [2];
   logic        e_ackr [2];
   logic        e_errr [2];
   logic [31:0] e_data [2];

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;
   int cyc     = 0;

   function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n, logic [3:0] b);
      logic [31:0] m;
      m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
      return (o & ~m) | (n & m);
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Effect of the coming clock edge on instance d, from the current inputs.
   task automatic model_edge(int d);
      logic        nv, ne, dv, de;
      logic [31:0] nd, dd;
      if (rst) begin
         icnt[d] = 0; pv[d] = 1'b0; pe[d] = 1'b0; pd[d] = '0;
         e_done[d] = 1'b0; e_ackw[d] = 1'b0; e_errw[d] = 1'b0;
         e_ackr[d] = 1'b0; e_errr[d] = 1'b0; e_data[d] = '0;
         return;
      end
      nv = 1'b0; ne = 1'b0; nd = '0;
      e_ackw[d] = 1'b0; e_errw[d] = 1'b0;
      if (icnt[d] < depth[d]) begin
         mem[d][icnt[d]] = '0;
         icnt[d] = icnt[d] + 1;
         if (icnt[d] == depth[d]) e_done[d] = 1'b1;
      end else begin
         if (rd) begin
            nv = 1'b1;
            ne = (int'(rd_addr) >= depth[d]);
            if (ne) nd = '0;
            else if (wr && wr_addr == rd_addr) nd = merge(mem[d][rd_addr], wr_data, be);
            else nd = mem[d][rd_addr];
         end
         if (wr) begin
            e_ackw[d] = 1'b1;
            e_errw[d] = (int'(wr_addr) >= depth[d]);
            if (!e_errw[d]) mem[d][wr_addr] = merge(mem[d][wr_addr], wr_data, be);
         end
      end
      if (lat[d] == 1) begin
         dv = nv; de = ne; dd = nd;
      end else begin
         dv = pv[d]; de = pe[d]; dd = pd[d];
         pv[d] = nv; pe[d] = ne; pd[d] = nd;
      end
      e_ackr[d] = dv;
      e_errr[d] = dv && de;
      if (dv) e_data[d] = dd;
   endtask

   task automatic check_all();
      string s;
      s = $sformatf("@%0d", cyc);
      check({"a_init_done", s}, 32'(a_done), 32'(e_done[0]));
      check({"a_ack_wr", s},    32'(a_ackw), 32'(e_ackw[0]));
      check({"a_err_wr", s},    32'(a_errw), 32'(e_errw[0]));
      check({"a_ack_rd", s},    32'(a_ackr), 32'(e_ackr[0]));
      check({"a_err_rd", s},    32'(a_errr), 32'(e_errr[0]));
      check({"a_rd_data", s},   a_data,      e_data[0]);
      check({"b_init_done", s}, 32'(b_done), 32'(e_done[1]));
      check({"b_ack_wr", s},    32'(b_ackw), 32'(e_ackw[1]));
      check({"b_err_wr", s},    32'(b_errw), 32'(e_errw[1]));
      check({"b_ack_rd", s},    32'(b_ackr), 32'(e_ackr[1]));
      check({"b_err_rd", s},    32'(b_errr), 32'(e_errr[1]));
      check({"b_rd_data", s},   b_data,      e_data[1]);
   endtask

   task automatic tick();
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      check_all();
   endtask

   task automatic set_wr(logic w, logic [3:0] a, logic [31:0] dat, logic [3:0] b);
      wr = w; wr_addr = a; wr_data = dat; be = b;
   endtask

   task automatic set_rd(logic r, logic [3:0] a);
      rd = r; rd_addr = a;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      depth[0] = 16; lat[0] = 1;
      depth[1] = 12; lat[1] = 2;
      for (int d = 0; d < 2; d++) icnt[d] = 0;
      rst = 1'b1;
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      set_rd(1'b0, 4'd0);

      // reset state
      tick();
      tick();

      // clear sequence: reads every cycle, writes ignored while clearing
      rst = 1'b0;
      n = 0;
      while (a_done !== 1'b1 && n < 40) begin
         set_wr(1'($urandom), 4'($urandom), $urandom, 4'($urandom));
         set_rd(1'b1, 4'd3);
         tick();
         n = n + 1;
      end
      check("init_len_a", 32'(n), 32'd16);
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      set_rd(1'b1, 4'd3);
      tick();
      check("first_read_a_ack", 32'(a_ackr), 32'd1);
      check("first_read_a_data", a_data, 32'h0000_0000);

      // byte enables
      set_rd(1'b0, 4'd0);
      set_wr(1'b1, 4'd5, 32'hAABB_CCDD, 4'b1111);
      tick();
      check("be_ack_wr1", 32'(a_ackw), 32'd1);
      set_wr(1'b1, 4'd5, 32'h1122_3344, 4'b0101);
      tick();
      check("be_ack_wr2", 32'(a_ackw), 32'd1);
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      set_rd(1'b1, 4'd5);
      tick();
      check("be_read_a", a_data, 32'hAA22_CC44);
      check("lat2_no_ack_yet", 32'(b_ackr), 32'd0);
      set_rd(1'b0, 4'd0);
      tick();
      check("be_read_b", b_data, 32'hAA22_CC44);
      check("lat2_ack", 32'(b_ackr), 32'd1);
      tick();
      check("lat2_ack_pulse", 32'(b_ackr), 32'd0);

      // back-to-back reads 0..3
      for (int i = 0; i < 4; i++) begin
         set_rd(1'b1, 4'(i));
         tick();
      end
      set_rd(1'b0, 4'd0);
      tick();
      tick();

      // write-first bypass
      set_wr(1'b1, 4'd7, 32'h0102_0304, 4'b1111);
      tick();
      set_wr(1'b1, 4'd7, 32'hFFFF_FFFF, 4'b1000);
      set_rd(1'b1, 4'd7);
      tick();
      check("bypass_a", a_data, 32'hFF02_0304);
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      set_rd(1'b0, 4'd0);
      tick();
      check("bypass_b", b_data, 32'hFF02_0304);

      // address range (instance b has DEPTH 12)
      set_wr(1'b1, 4'd13, 32'hDEAD_BEEF, 4'b1111);
      tick();
      check("range_wr_err_b", 32'(b_errw), 32'd1);
      check("range_wr_ack_b", 32'(b_ackw), 32'd1);
      check("range_wr_err_a", 32'(a_errw), 32'd0);
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      set_rd(1'b1, 4'd12);
      tick();
      set_rd(1'b1, 4'd1);
      tick();
      check("range_rd_err_b", 32'(b_errr), 32'd1);
      check("range_rd_data_b", b_data, 32'h0000_0000);
      set_rd(1'b0, 4'd0);
      tick();
      tick();

      // randomized traffic with frequent same-address collisions
      for (int i = 0; i < 400; i++) begin
         set_wr(1'($urandom), 4'($urandom), $urandom, 4'($urandom));
         if ($urandom_range(3) == 0) set_rd(1'($urandom), wr_addr);
         else set_rd(1'($urandom), 4'($urandom));
         tick();
      end
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      set_rd(1'b0, 4'd0);
      tick();

      // reset while a latency-2 read is in flight, with a write in the reset cycle
      set_wr(1'b1, 4'd5, 32'h5555_5555, 4'b1111);
      tick();
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      set_rd(1'b1, 4'd5);
      tick();
      rst = 1'b1;
      set_rd(1'b0, 4'd0);
      set_wr(1'b1, 4'd2, 32'h1234_5678, 4'b1111);
      tick();
      check("rst_drop_ack_b", 32'(b_ackr), 32'd0);
      check("rst_drop_ackw_a", 32'(a_ackw), 32'd0);
      rst = 1'b0;
      set_wr(1'b0, 4'd0, 32'd0, 4'd0);
      n = 0;
      while (a_done !== 1'b1 && n < 40) begin
         set_rd(1'b1, 4'($urandom));
         tick();
         n = n + 1;
      end
      check("init_len_a_again", 32'(n), 32'd16);
      set_rd(1'b1, 4'd5);
      tick();
      check("after_rst_addr5_a", a_data, 32'h0000_0000);
      set_rd(1'b1, 4'd2);
      tick();
      check("after_rst_addr2_a", a_data, 32'h0000_0000);
      check("after_rst_addr5_b", b_data, 32'h0000_0000);
      set_rd(1'b0, 4'd0);
      tick();
      check("after_rst_addr2_b", b_data, 32'h0000_0000);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
